// File: rtl/mcu_rotating_bank_ctrl_if.sv
// Host/convolver/bank bus of the rotating bank controller, grouped into one interface.
// Latency: none in the interface itself.
// Backpressure: none; all signals are strobes or level signals. master = host side, slave = controller.
interface mcu_rotating_bank_ctrl_if #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    parameter int BITS_ADDR   = 10
);
    localparam int M = N + K - 1;

    // host / convolver / bank inputs to the controller
    logic [BITS_IMAGEN-1:0]     i_Data;
    logic [N*BITS_DATA-1:0]     i_DataConv;
    logic [M*BITS_DATA-1:0]     i_MemData;
    logic [BITS_ADDR-1:0]       i_WAddr;
    logic [BITS_ADDR-1:0]       i_RAddr;
    logic                       i_sop;
    logic                       i_eop;
    logic                       i_chblk;

    // controller outputs
    logic [K*N*BITS_IMAGEN-1:0] o_DataConv;
    logic [BITS_DATA-1:0]       o_Data;
    logic                       o_valid;
    logic [M-1:0]               o_we;
    logic [BITS_ADDR-1:0]       o_WAddr;
    logic [BITS_ADDR-1:0]       o_RAddr;
    logic [M*BITS_DATA-1:0]     o_MemData;
    logic [1:0]                 o_state;

    modport master (
        output i_Data, i_DataConv, i_MemData, i_WAddr, i_RAddr, i_sop, i_eop, i_chblk,
        input  o_DataConv, o_Data, o_valid, o_we, o_WAddr, o_RAddr, o_MemData, o_state
    );

    modport slave (
        input  i_Data, i_DataConv, i_MemData, i_WAddr, i_RAddr, i_sop, i_eop, i_chblk,
        output o_DataConv, o_Data, o_valid, o_we, o_WAddr, o_RAddr, o_MemData, o_state
    );
endinterface

// File: rtl/mcu_rotating_bank_ctrl.sv
// Memory control unit: rotates M=N+K-1 banks through LOAD/RUN/DRAIN, feeding N convolvers K-row windows.
// Latency: o_we/o_MemData/o_WAddr/o_RAddr combinational; o_DataConv/o_valid/o_Data registered, 1 cycle.
// Backpressure: none; the host paces the FSM with i_sop/i_eop/i_chblk pulses.
// Ports: clk, rst (sync active-high), bus (slave modport of mcu_rotating_bank_ctrl_if).
module mcu_rotating_bank_ctrl #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    parameter int BITS_ADDR   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    mcu_rotating_bank_ctrl_if.slave  bus
);
    localparam int M  = N + K - 1;
    localparam int BW = (M > 1) ? $clog2(M) : 1;
    localparam logic [BW:0] M_W = (BW+1)'(M);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       base, base_nxt;
    logic [BW-1:0]       ldptr, ldptr_nxt;
    logic [BW-1:0]       rdptr, rdptr_nxt;
    logic                eop_flag, eop_nxt;

    logic [M-1:0]               we;
    logic [M*BITS_DATA-1:0]     mem_wdat;
    logic [K*N*BITS_IMAGEN-1:0] win;
    logic [K*N*BITS_IMAGEN-1:0] conv_q;
    logic                       valid_q;
    logic [BITS_DATA-1:0]       drain_q;

    // Physical bank of logical row x. base and x are both < M, so a single
    // conditional subtract is enough to wrap.
    function automatic logic [BW-1:0] bank_idx(input logic [BW-1:0] b, input logic [BW-1:0] x);
        logic [BW:0] s;
        s = {1'b0, b} + {1'b0, x};
        if (s >= M_W) begin
            s = s - M_W;
        end
        return s[BW-1:0];
    endfunction

    // Convolver n sees logical rows n..n+K-1, low pixel bits of each bank word.
    always_comb begin
        win = '0;
        for (int n = 0; n < N; n++) begin
            for (int k = 0; k < K; k++) begin
                win[(n*K+k)*BITS_IMAGEN +: BITS_IMAGEN] =
                    bus.i_MemData[int'(bank_idx(base, BW'(n+k)))*BITS_DATA +: BITS_IMAGEN];
            end
        end
    end

    // Next-state and bank write-port decode.
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        ldptr_nxt = ldptr;
        rdptr_nxt = rdptr;
        eop_nxt   = eop_flag;
        we        = '0;
        mem_wdat  = '0;

        case (state)
            IDLE: begin
                if (bus.i_sop) begin
                    state_nxt = LOAD;
                    ldptr_nxt = '0;
                    base_nxt  = '0;
                    eop_nxt   = 1'b0;
                end
            end

            LOAD: begin
                // The bank at the load pointer is written every LOAD cycle,
                // including the cycle that carries an abort.
                we[bank_idx(base, ldptr)] = 1'b1;
                mem_wdat[int'(bank_idx(base, ldptr))*BITS_DATA +: BITS_DATA] = BITS_DATA'(bus.i_Data);
                if (bus.i_eop) begin
                    state_nxt = IDLE;
                end else if (bus.i_chblk) begin
                    if (ldptr == BW'(M-1)) begin
                        state_nxt = RUN;
                    end else begin
                        ldptr_nxt = ldptr + BW'(1);
                    end
                end
            end

            RUN: begin
                // Results of convolver n land in the bank holding logical row n,
                // which is the one retired at the end of this block.
                for (int n = 0; n < N; n++) begin
                    we[bank_idx(base, BW'(n))] = 1'b1;
                    mem_wdat[int'(bank_idx(base, BW'(n)))*BITS_DATA +: BITS_DATA] =
                        bus.i_DataConv[n*BITS_DATA +: BITS_DATA];
                end
                if (bus.i_chblk || bus.i_eop) begin
                    state_nxt = DRAIN;
                    rdptr_nxt = '0;
                    eop_nxt   = eop_flag | bus.i_eop;
                end
            end

            DRAIN: begin
                eop_nxt = eop_flag | bus.i_eop;
                if (bus.i_chblk) begin
                    if (rdptr == BW'(N-1)) begin
                        if (eop_flag) begin
                            state_nxt = IDLE;
                        end else begin
                            // Retired banks become the top of the window; the
                            // K-1 overlapping rows stay in place.
                            state_nxt = LOAD;
                            base_nxt  = bank_idx(base, BW'(N));
                            ldptr_nxt = BW'(K-1);
                        end
                    end else begin
                        rdptr_nxt = rdptr + BW'(1);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            ldptr    <= '0;
            rdptr    <= '0;
            eop_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            base     <= base_nxt;
            ldptr    <= ldptr_nxt;
            rdptr    <= rdptr_nxt;
            eop_flag <= eop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_q  <= '0;
            valid_q <= 1'b0;
            drain_q <= '0;
        end else begin
            valid_q <= (state == RUN);
            if (state == RUN) begin
                conv_q <= win;
            end
            if (state == DRAIN) begin
                drain_q <= bus.i_MemData[int'(bank_idx(base, rdptr))*BITS_DATA +: BITS_DATA];
            end
        end
    end

    assign bus.o_WAddr    = bus.i_WAddr;
    assign bus.o_RAddr    = bus.i_RAddr;
    assign bus.o_we       = we;
    assign bus.o_MemData  = mem_wdat;
    assign bus.o_DataConv = conv_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_Data     = drain_q;
    assign bus.o_state    = state;

endmodule

// File: tb/tb_mcu_rotating_bank_ctrl.sv
module tb_mcu_rotating_bank_ctrl;
    localparam int N  = 2;
    localparam int K  = 3;
    localparam int M  = N + K - 1;
    localparam int BI = 8;
    localparam int BD = 13;
    localparam int BA = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcu_rotating_bank_ctrl_if #(.N(N), .K(K), .BITS_IMAGEN(BI), .BITS_DATA(BD), .BITS_ADDR(BA)) bus ();

    mcu_rotating_bank_ctrl #(.N(N), .K(K), .BITS_IMAGEN(BI), .BITS_DATA(BD), .BITS_ADDR(BA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: logical row x lives in physical bank (base + x) % M.
    int m_state, m_base, m_ld, m_rd;
    bit m_eop;
    logic [K*N*BI-1:0] e_conv;
    logic              e_valid;
    logic [BD-1:0]     e_data;
    logic [M-1:0]      e_we;
    logic [M*BD-1:0]   e_mem;

    function automatic int phys(input int x);
        return (m_base + x) % M;
    endfunction

    task automatic model_comb();
        e_we  = '0;
        e_mem = '0;
        if (m_state == 1) begin
            e_we[phys(m_ld)] = 1'b1;
            e_mem[phys(m_ld)*BD +: BD] = BD'(bus.i_Data);
        end else if (m_state == 2) begin
            for (int n = 0; n < N; n++) begin
                e_we[phys(n)] = 1'b1;
                e_mem[phys(n)*BD +: BD] = bus.i_DataConv[n*BD +: BD];
            end
        end
    endtask

    task automatic model_step();
        bit old_eop;
        if (rst) begin
            m_state = 0; m_base = 0; m_ld = 0; m_rd = 0; m_eop = 0;
            e_conv = '0; e_valid = 1'b0; e_data = '0;
        end else begin
            e_valid = (m_state == 2);
            if (m_state == 2)
                for (int n = 0; n < N; n++)
                    for (int k = 0; k < K; k++)
                        e_conv[(n*K+k)*BI +: BI] = bus.i_MemData[phys(n+k)*BD +: BI];
            if (m_state == 3)
                e_data = bus.i_MemData[phys(m_rd)*BD +: BD];
            case (m_state)
                0: if (bus.i_sop) begin m_state = 1; m_ld = 0; m_base = 0; m_eop = 0; end
                1: begin
                    if (bus.i_eop) m_state = 0;
                    else if (bus.i_chblk) begin
                        if (m_ld == M-1) m_state = 2;
                        else m_ld++;
                    end
                end
                2: if (bus.i_chblk || bus.i_eop) begin
                    m_state = 3; m_rd = 0;
                    if (bus.i_eop) m_eop = 1;
                end
                default: begin
                    old_eop = m_eop;
                    if (bus.i_eop) m_eop = 1;
                    if (bus.i_chblk) begin
                        if (m_rd == N-1) begin
                            if (old_eop) m_state = 0;
                            else begin
                                m_base = phys(N); m_ld = K-1; m_state = 1;
                            end
                        end else m_rd++;
                    end
                end
            endcase
        end
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic clk_edge();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_sop = 0; bus.i_eop = 0; bus.i_chblk = 0;
    endtask

    task automatic test_reset();
        clear_in();
        bus.i_Data = '0; bus.i_DataConv = '0; bus.i_MemData = '0;
        bus.i_WAddr = '0; bus.i_RAddr = '0;
        rst = 1;
        settle(); clk_edge(); clk_edge();
        checks++; if (bus.o_state !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.o_state); else passes++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.o_valid); else passes++;
        checks++; if (bus.o_DataConv !== '0) $display("FAIL reset_conv got %h want 0", bus.o_DataConv); else passes++;
        checks++; if (bus.o_Data !== '0) $display("FAIL reset_data got %h want 0", bus.o_Data); else passes++;
        checks++; if (bus.o_we !== '0) $display("FAIL reset_we got %b want 0", bus.o_we); else passes++;
        checks++; if (bus.o_MemData !== '0) $display("FAIL reset_memdata got %h want 0", bus.o_MemData); else passes++;
        rst = 0;
        bus.i_sop = 1; settle(); clk_edge(); bus.i_sop = 0;
        bus.i_Data = 8'h77; bus.i_chblk = 1; settle(); clk_edge(); bus.i_chblk = 0;
        rst = 1; settle(); clk_edge(); rst = 0;
        settle();
        checks++; if (bus.o_state !== 2'd0) $display("FAIL midload_rst_state got %0d want 0", bus.o_state); else passes++;
        checks++; if (bus.o_we !== 4'b0000) $display("FAIL midload_rst_we got %b want 0000", bus.o_we); else passes++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL midload_rst_valid got %b want 0", bus.o_valid); else passes++;
        bus.i_sop = 1; clk_edge(); bus.i_sop = 0; settle();
        checks++; if (bus.o_state !== 2'd1) $display("FAIL rst_sop_state got %0d want 1", bus.o_state); else passes++;
        checks++; if (bus.o_we !== 4'b0001) $display("FAIL rst_sop_ldptr0 got %b want 0001", bus.o_we); else passes++;
    endtask

    task automatic test_initial_load();
        logic [M*BD-1:0] em;
        logic [BI-1:0]   pix;
        rst = 1; settle(); clk_edge(); rst = 0;
        bus.i_sop = 1; settle();
        checks++; if (bus.o_we !== 4'b0000) $display("FAIL idle_we got %b want 0000", bus.o_we); else passes++;
        clk_edge(); bus.i_sop = 0;
        for (int b = 0; b < M; b++) begin
            pix = BI'(8'h11 * (b + 1));
            em = '0;
            em[b*BD +: BD] = BD'(pix);
            bus.i_Data = pix; bus.i_chblk = 0; settle();
            checks++; if (bus.o_we !== 4'(1 << b)) $display("FAIL load_we_%0d got %b want %b", b, bus.o_we, 4'(1 << b)); else passes++;
            clk_edge();
            bus.i_chblk = 1; settle();
            checks++; if (bus.o_MemData !== em) $display("FAIL load_data_%0d got %h want %h", b, bus.o_MemData, em); else passes++;
            clk_edge();
        end
        bus.i_chblk = 0;
        checks++; if (bus.o_state !== 2'd2) $display("FAIL load_to_run got %0d want 2", bus.o_state); else passes++;
    endtask

    task automatic test_window();
        bus.i_MemData  = {13'h113, 13'h012, 13'h111, 13'h010};
        bus.i_DataConv = {13'h1AB, 13'h0CD};
        settle();
        checks++; if (bus.o_we !== 4'b0011) $display("FAIL run_we got %b want 0011", bus.o_we); else passes++;
        checks++; if (bus.o_MemData !== {13'h0, 13'h0, 13'h1AB, 13'h0CD}) $display("FAIL run_wb_data got %h", bus.o_MemData); else passes++;
        clk_edge();
        checks++; if (bus.o_valid !== 1'b1) $display("FAIL window_valid got %b want 1", bus.o_valid); else passes++;
        checks++; if (bus.o_DataConv !== 48'h131211_121110) $display("FAIL window_rows got %h want 131211121110", bus.o_DataConv); else passes++;
    endtask

    task automatic test_drain_rotate();
        bus.i_chblk = 1; settle(); clk_edge();
        checks++; if (bus.o_state !== 2'd3) $display("FAIL run_to_drain got %0d want 3", bus.o_state); else passes++;
        checks++; if (bus.o_valid !== 1'b1) $display("FAIL valid_after_last_run got %b want 1", bus.o_valid); else passes++;
        bus.i_MemData = {13'h0AA, 13'h0BB, 13'h1AB, 13'h0CD};
        settle();
        checks++; if (bus.o_we !== 4'b0000) $display("FAIL drain_we got %b want 0000", bus.o_we); else passes++;
        clk_edge();
        checks++; if (bus.o_Data !== 13'h0CD) $display("FAIL drain_bank0 got %h want 0cd", bus.o_Data); else passes++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", bus.o_valid); else passes++;
        settle(); clk_edge();
        checks++; if (bus.o_Data !== 13'h1AB) $display("FAIL drain_bank1 got %h want 1ab", bus.o_Data); else passes++;
        checks++; if (bus.o_state !== 2'd1) $display("FAIL drain_to_load got %0d want 1", bus.o_state); else passes++;
        bus.i_Data = 8'h55; settle();
        checks++; if (bus.o_we !== 4'b0001) $display("FAIL reload_we0 got %b want 0001", bus.o_we); else passes++;
        checks++; if (bus.o_MemData !== 52'h055) $display("FAIL reload_data0 got %h want 055", bus.o_MemData); else passes++;
        clk_edge();
        bus.i_Data = 8'h66; settle();
        checks++; if (bus.o_we !== 4'b0010) $display("FAIL reload_we1 got %b want 0010", bus.o_we); else passes++;
        clk_edge();
        bus.i_chblk = 0;
        checks++; if (bus.o_state !== 2'd2) $display("FAIL reload_to_run got %0d want 2", bus.o_state); else passes++;
        bus.i_MemData = {13'h023, 13'h022, 13'h021, 13'h020};
        settle();
        checks++; if (bus.o_we !== 4'b1100) $display("FAIL rot_we got %b want 1100", bus.o_we); else passes++;
        clk_edge();
        checks++; if (bus.o_DataConv !== 48'h212023_202322) $display("FAIL rot_window got %h want 212023202322", bus.o_DataConv); else passes++;
    endtask

    task automatic test_end_of_frame();
        bus.i_eop = 1; bus.i_chblk = 1; settle(); clk_edge(); bus.i_eop = 0;
        checks++; if (bus.o_state !== 2'd3) $display("FAIL eof_drain got %0d want 3", bus.o_state); else passes++;
        settle(); clk_edge();
        checks++; if (bus.o_state !== 2'd3) $display("FAIL eof_drain1 got %0d want 3", bus.o_state); else passes++;
        settle(); clk_edge(); bus.i_chblk = 0;
        checks++; if (bus.o_state !== 2'd0) $display("FAIL eof_idle got %0d want 0", bus.o_state); else passes++;
        settle(); clk_edge();
        checks++; if (bus.o_state !== 2'd0) $display("FAIL eof_stay_idle got %0d want 0", bus.o_state); else passes++;
    endtask

    task automatic test_abort_ignore();
        bus.i_sop = 1; settle(); clk_edge(); bus.i_sop = 0;
        bus.i_Data = 8'h99; bus.i_eop = 1; bus.i_chblk = 1; settle();
        checks++; if (bus.o_we !== 4'b0001) $display("FAIL abort_cycle_we got %b want 0001", bus.o_we); else passes++;
        clk_edge(); clear_in(); settle();
        checks++; if (bus.o_state !== 2'd0) $display("FAIL abort_idle got %0d want 0", bus.o_state); else passes++;
        checks++; if (bus.o_we !== 4'b0000) $display("FAIL abort_we got %b want 0000", bus.o_we); else passes++;
        bus.i_sop = 1; clk_edge(); bus.i_sop = 0;
        bus.i_chblk = 1;
        for (int b = 0; b < M; b++) begin settle(); clk_edge(); end
        bus.i_chblk = 0; bus.i_sop = 1; settle(); clk_edge(); bus.i_sop = 0; settle();
        checks++; if (bus.o_state !== 2'd2) $display("FAIL sop_in_run_state got %0d want 2", bus.o_state); else passes++;
        checks++; if (bus.o_we !== 4'b0011) $display("FAIL sop_in_run_base got %b want 0011", bus.o_we); else passes++;
        clk_edge();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(99) == 0);
            bus.i_sop      = ($urandom_range(5) == 0);
            bus.i_eop      = ($urandom_range(24) == 0);
            bus.i_chblk    = ($urandom_range(1) == 0);
            bus.i_Data     = BI'($urandom);
            bus.i_DataConv = (N*BD)'({$urandom, $urandom});
            bus.i_MemData  = (M*BD)'({$urandom, $urandom});
            bus.i_WAddr    = BA'($urandom);
            bus.i_RAddr    = BA'($urandom);
            settle();
            checks++; if (bus.o_we !== e_we) $display("FAIL rnd_we cyc %0d got %b want %b", i, bus.o_we, e_we); else passes++;
            checks++; if (bus.o_MemData !== e_mem) $display("FAIL rnd_memdata cyc %0d got %h want %h", i, bus.o_MemData, e_mem); else passes++;
            checks++; if (bus.o_WAddr !== bus.i_WAddr || bus.o_RAddr !== bus.i_RAddr)
                $display("FAIL rnd_addr cyc %0d got %h/%h", i, bus.o_WAddr, bus.o_RAddr); else passes++;
            clk_edge();
            checks++; if (bus.o_state !== 2'(m_state)) $display("FAIL rnd_state cyc %0d got %0d want %0d", i, bus.o_state, m_state); else passes++;
            checks++; if (bus.o_valid !== e_valid) $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.o_valid, e_valid); else passes++;
            checks++; if (bus.o_DataConv !== e_conv) $display("FAIL rnd_conv cyc %0d got %h want %h", i, bus.o_DataConv, e_conv); else passes++;
            checks++; if (bus.o_Data !== e_data) $display("FAIL rnd_data cyc %0d got %h want %h", i, bus.o_Data, e_data); else passes++;
        end
        rst = 0;
        clear_in();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_initial_load();
        test_window();
        test_drain_rotate();
        test_end_of_frame();
        test_abort_ignore();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mcu_rotating_bank_ctrl.md
Name: mcu_rotating_bank_ctrl

Overview:
- Memory control unit for the 2D convolution datapath, generalised to kernel height K and N parallel convolvers over M = N+K-1 block-RAM banks.
- Owns an internal bank-rotation FSM. It loads image columns into the banks, presents K-row windows to each convolver, and writes results back into the retiring banks.
- Exposes those results to the host for drain, then recycles the retiring banks for new columns.
- Sits between the host loader/readback logic, the N convolvers and the M banks.

Parameters:
- N, 2, number of parallel convolvers (>=1).
- K, 3, kernel height in rows (>=2).
- BITS_IMAGEN, 8, pixel width.
- BITS_DATA, 13, bank word / convolution result width (>= BITS_IMAGEN).
- BITS_ADDR, 10, bank address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_Data  in  BITS_IMAGEN  pixel from host loader.
- i_DataConv  in  N*BITS_DATA  convolver results; slice n = convolver n.
- i_MemData  in  M*BITS_DATA  bank read data; slice b = bank b; 1-cycle RAM read latency.
- i_WAddr, i_RAddr  in  BITS_ADDR  host-driven write/read addresses.
- i_sop, i_eop, i_chblk  in  1  start of frame, end of frame, block-change pulse.
- o_DataConv  out  K*N*BITS_IMAGEN  convolver windows.
- o_Data  out  BITS_DATA  drained result to host.
- o_valid  out  1  o_DataConv valid.
- o_we  out  M  per-bank write enables.
- o_WAddr, o_RAddr  out  BITS_ADDR  addresses to banks.
- o_MemData  out  M*BITS_DATA  per-bank write data.
- o_state  out  2  FSM state, for debug.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE(0), base=0, ldptr=0, rdptr=0, eop_flag=0. On the following cycle o_DataConv=0, o_Data=0, o_valid=0, o_we=0, o_MemData=0.
- o_WAddr=i_WAddr and o_RAddr=i_RAddr, combinational pass-through with zero latency.
- Bank index arithmetic: bank(x) = (base+x) mod M, computed by conditional subtract. No operand reaches 2M.
- States: IDLE(0), LOAD(1), RUN(2), DRAIN(3).
- IDLE:
  - i_sop -> LOAD with ldptr=0, base=0.
  - All other inputs ignored; o_we=0.
- LOAD:
  - o_we is one-hot on bank(ldptr); that bank's o_MemData = zero-extended i_Data. Every cycle writes.
  - i_chblk: if ldptr==M-1 -> RUN; else ldptr++.
  - i_eop -> IDLE immediately (abort; no drain).
- RUN:
  - Window mapping: o_DataConv[(n*K+k)*BITS_IMAGEN +: BITS_IMAGEN] <= i_MemData slice bank(n+k), low BITS_IMAGEN bits.
  - o_DataConv and o_valid are registered, 1-cycle latency; o_valid=1 on every cycle after a RUN cycle.
  - Result write-back: o_we[bank(n)]=1 with o_MemData slice = i_DataConv slice n, for n in 0..N-1. All other banks have we=0.
  - i_chblk or i_eop -> DRAIN, rdptr=0. eop_flag is set if i_eop.
- DRAIN:
  - o_Data <= i_MemData slice bank(rdptr), registered, 1-cycle latency. o_we=0.
  - i_eop during DRAIN sets eop_flag.
  - i_chblk with rdptr==N-1:
    - eop_flag=1 -> IDLE.
    - Otherwise base <= bank(N), ldptr <= K-1, next state LOAD. Only the N freed banks are reloaded, with K-1 rows retained.
  - i_chblk with rdptr<N-1: rdptr++.
- Unselected o_MemData slices = 0.
- Outside RUN, o_valid=0. o_DataConv holds its last value outside RUN.
- Simultaneous events:
  - i_sop outside IDLE is ignored.
  - i_eop and i_chblk together in LOAD: eop wins.
  - i_eop and i_chblk together in RUN: one DRAIN entry with eop_flag=1.
- rst mid-operation: reset values apply at that edge regardless of state; bank contents are not cleared.
- N=1: drain is one block; window rows are banks base..base+K-1.

Test Plan:
- Reset: N=2, K=3 (M=4); assert rst mid-LOAD -> state=0, o_we=0, o_valid=0 on the next cycle; a following i_sop enters LOAD with ldptr=0.
- Initial load: i_sop, then 4 blocks of pixels 0x11/0x22/0x33/0x44 separated by i_chblk.
  - o_we sequences 0001, 0010, 0100, 1000; o_MemData slices carry 0x011/0x022/0x033/0x044.
  - State=RUN after the 4th chblk.
- Window mapping: in RUN, bank b low byte = 0x10+b.
  - Conv0 rows = 0x10, 0x11, 0x12; conv1 rows = 0x11, 0x12, 0x13.
  - Both appear one cycle later with o_valid=1.
  - i_DataConv = {0x1AB, 0x0CD} gives o_we=0011, bank0 data 0x0CD, bank1 data 0x1AB.
- Drain and rotate: chblk in RUN, then 2 drain chblks.
  - o_Data returns bank0 then bank1 data.
  - base becomes 2, state=LOAD with ldptr=2; the next loads write banks 0 and 1 (o_we 0001, 0010).
  - In the next RUN, conv0 rows = banks 2, 3, 0.
- End of frame: i_eop together with i_chblk in RUN -> DRAIN; after 2 drain chblks -> IDLE, with no LOAD entered.
- Abort and ignore: i_eop in LOAD -> IDLE the next cycle with o_we=0; i_sop asserted during RUN -> state and base unchanged.
